ethernet_tx_sched: RTL and testbench



---
 rtl/ethernet_tx_sched_pkg.sv | 20 ++
 rtl/ethernet_tx_sched_fifo.sv | 58 +++++
 rtl/ethernet_tx_sched.sv | 128 ++++++++++++
 tb/tb_ethernet_tx_sched.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ethernet_tx_sched_pkg.sv
// Shared types and constants for the Ethernet transmit scheduler.
package ethernet_tx_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_TXEN,
        WAIT_DONE,
        GAP
    } tx_sched_state_t;

    localparam int TX_WORD_W         = 16;
    localparam int MAC_PAYLOAD_BYTES = 5;

    // Zero-extends a queued word to the MAC's payload width at the instantiation site.
    function automatic logic [MAC_PAYLOAD_BYTES*8-1:0] mac_payload(input logic [TX_WORD_W-1:0] w);
        return {{(MAC_PAYLOAD_BYTES*8-TX_WORD_W){1'b0}}, w};
    endfunction

endpackage

// File: rtl/ethernet_tx_sched_fifo.sv
// tx_word_fifo: show-ahead word FIFO. The occupancy count is kept apart from
// the pointers so full and empty never alias. Storage is not reset; a reset
// only clears pointers and count, which discards anything queued.
module tx_word_fifo
    import ethernet_tx_sched_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [TX_WORD_W-1:0]   din,
    output logic [TX_WORD_W-1:0]   dout,
    output logic [$clog2(DEPTH):0] fill,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = PTR_W + 1;

    logic [TX_WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 do_pop;
    logic                 do_push;

    assign full    = (fill == FILL_W'(DEPTH));
    assign empty   = (fill == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

    // Word storage write port.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ethernet_tx_sched.sv
// ethernet_tx_sched: queues bus read responses and issues them to mac_tx one
// frame at a time, waiting out txen and a programmable inter-frame gap.
// Optional build macro ETHERNET_TX_SCHED_STATS_EN adds frames_o / drops_o.
module ethernet_tx_sched
    import ethernet_tx_sched_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int IFG_CYCLES   = 48,
    parameter int TXEN_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [TX_WORD_W-1:0]   data_i,
    input  logic                   rw_i,
    input  logic                   valid_i,
    input  logic                   txen_i,
    output logic [TX_WORD_W-1:0]   payload_o,
    output logic                   start_o,
    output logic [$clog2(DEPTH):0] fill_o,
    output logic                   overflow_o,
`ifdef ETHERNET_TX_SCHED_STATS_EN
    output logic [31:0]            frames_o,
    output logic [15:0]            drops_o,
`endif
    output logic                   timeout_o
);

    localparam int CNT_MAX = (IFG_CYCLES > TXEN_TIMEOUT) ? IFG_CYCLES : TXEN_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    tx_sched_state_t      state;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 push_req;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [TX_WORD_W-1:0] fifo_dout;

    assign push_req = valid_i && !rw_i;
    assign pop      = (state == IDLE) && !fifo_empty;
    // The counter parks at all-ones rather than wrapping back into range.
    assign cnt_inc  = (cnt == '1) ? cnt : cnt + 1'b1;

    tx_word_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_req),
        .pop   (pop),
        .din   (data_i),
        .dout  (fifo_dout),
        .fill  (fill_o),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Frame issue FSM: start pulse, txen handshake, timeout and inter-frame gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            payload_o <= '0;
            start_o   <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            start_o   <= 1'b0;
            timeout_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        payload_o <= fifo_dout;
                        start_o   <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    cnt   <= '0;
                    state <= WAIT_TXEN;
                end
                WAIT_TXEN: begin
                    if (txen_i) begin
                        state <= WAIT_DONE;
                    end else if (cnt == CNT_W'(TXEN_TIMEOUT - 1)) begin
                        // Restart the count so the gap after an abandoned frame is full length.
                        timeout_o <= 1'b1;
                        cnt       <= '0;
                        state     <= GAP;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                WAIT_DONE: begin
                    if (!txen_i) begin
                        cnt   <= '0;
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (cnt == CNT_W'(IFG_CYCLES - 1)) state <= IDLE;
                    else                               cnt   <= cnt_inc;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Dropped-response pulse: push into a full FIFO with no pop to make room.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overflow_o <= 1'b0;
        else        overflow_o <= push_req && fifo_full && !pop;
    end

`ifdef ETHERNET_TX_SCHED_STATS_EN
    // Frame counter wraps; drop counter sticks at its maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_o <= '0;
            drops_o  <= '0;
        end else begin
            if (start_o)                       frames_o <= frames_o + 32'd1;
            if (overflow_o && drops_o != '1)   drops_o  <= drops_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ethernet_tx_sched.sv
// Self-checking bench for ethernet_tx_sched. The reference model keeps the
// queue as a SystemVerilog queue and predicts issue times from timestamps:
// a frame popped at edge s frees the scheduler at s+2+a+L+IFG (txen rising
// after a cycles for L cycles) or s+2+TMO+IFG when txen never rises.
module tb_ethernet_tx_sched;
    import ethernet_tx_sched_pkg::*;

    localparam int DEPTH = 4;
    localparam int IFG   = 4;
    localparam int TMO   = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] data_i = '0;
    logic        rw_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        txen_i = 1'b0;
    logic [15:0] payload_o;
    logic        start_o;
    logic [2:0]  fill_o;
    logic        overflow_o;
    logic        timeout_o;
`ifdef ETHERNET_TX_SCHED_STATS_EN
    logic [31:0] frames_o;
    logic [15:0] drops_o;
`endif

    ethernet_tx_sched #(
        .DEPTH        (DEPTH),
        .IFG_CYCLES   (IFG),
        .TXEN_TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_i     (data_i),
        .rw_i       (rw_i),
        .valid_i    (valid_i),
        .txen_i     (txen_i),
        .payload_o  (payload_o),
        .start_o    (start_o),
        .fill_o     (fill_o),
        .overflow_o (overflow_o),
`ifdef ETHERNET_TX_SCHED_STATS_EN
        .frames_o   (frames_o),
        .drops_o    (drops_o),
`endif
        .timeout_o  (timeout_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model state.
    logic [15:0] q[$];
    int          free_at = 0;
    int          to_edge = -1;
    int          cur_s = -1000;
    int          cur_a = 0;
    int          cur_l = 0;
    bit          fix_mac = 1'b1;
    int          fix_a = 3;
    int          fix_l = 20;
    bit          fix_to = 1'b0;
    logic [15:0] exp_payload = '0;
    bit          exp_start = 1'b0;
    bit          exp_ovf = 1'b0;
    int          exp_frames = 0;
    int          exp_drops = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic check_outputs();
        chk("start_o",    {31'd0, start_o},    {31'd0, exp_start});
        chk("payload_o",  {16'd0, payload_o},  {16'd0, exp_payload});
        chk("fill_o",     {29'd0, fill_o},     32'(q.size()));
        chk("overflow_o", {31'd0, overflow_o}, {31'd0, exp_ovf});
        chk("timeout_o",  {31'd0, timeout_o},  {31'd0, (cyc == to_edge)});
`ifdef ETHERNET_TX_SCHED_STATS_EN
        chk("frames_o",   frames_o,            32'(exp_frames));
        chk("drops_o",    {16'd0, drops_o},    32'(exp_drops));
`endif
    endtask

    // One clock: drive inputs, advance the model at the edge, check 1 time unit later.
    task automatic step(input bit v, input bit rw, input logic [15:0] d);
        bit pop_m;
        bit push_m;
        bit to;
        int a;
        int l;
        valid_i = v;
        rw_i    = rw;
        data_i  = d;
        txen_i  = (cyc >= cur_s + cur_a) && (cyc < cur_s + cur_a + cur_l);
        @(posedge clk);
        cyc++;
        if (exp_start) exp_frames++;
        if (exp_ovf && exp_drops != 65535) exp_drops++;
        pop_m     = (cyc >= free_at) && (q.size() > 0);
        push_m    = v && !rw;
        exp_ovf   = push_m && !((q.size() < DEPTH) || pop_m);
        exp_start = pop_m;
        if (pop_m) begin
            exp_payload = q.pop_front();
            a  = fix_mac ? fix_a  : int'($urandom_range(1, 5));
            l  = fix_mac ? fix_l  : int'($urandom_range(1, 10));
            to = fix_mac ? fix_to : ($urandom_range(0, 4) == 0);
            cur_s = cyc;
            cur_a = a;
            cur_l = to ? 0 : l;
            if (to) begin
                free_at = cyc + 2 + TMO + IFG;
                to_edge = cyc + 1 + TMO;
            end else begin
                free_at = cyc + 2 + a + l + IFG;
            end
        end
        if (push_m && !exp_ovf) q.push_back(d);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        valid_i = 1'b0;
        rst_n   = 1'b0;
        #1;
        q.delete();
        free_at     = 0;
        to_edge     = -1;
        exp_start   = 1'b0;
        exp_ovf     = 1'b0;
        exp_payload = '0;
        exp_frames  = 0;
        exp_drops   = 0;
        check_outputs();
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while ((q.size() != 0 || cyc < free_at) && n < maxc) begin
            step(1'b0, 1'b0, 16'h0);
            n++;
        end
        vectors++;
        assert (n < maxc)
        else begin
            miscompares++;
            $error("FAIL drain_bound observed=%0d cycles expected<%0d", n, maxc);
        end
    endtask

    initial begin
        #2;
        do_reset();

        // Single response pushed at edge 10, txen 3 cycles after start for 20 cycles.
        fix_mac = 1'b1; fix_a = 3; fix_l = 20; fix_to = 1'b0;
        while (cyc < 9) step(1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 16'hBEEF);
        drain(200);

        // Burst of three consecutive responses plus an ignored write.
        fix_a = 2; fix_l = 6;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'($urandom));
        step(1'b1, 1'b1, 16'hDEAD);
        drain(200);

        // Overflow while a long frame is on the wire, then full-plus-pop.
        fix_a = 1; fix_l = 40;
        step(1'b1, 1'b0, 16'h1111);
        repeat (3) step(1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h2000 + 16'(i));
        while (cyc + 1 < free_at) step(1'b0, 1'b0, 16'h0);
        fix_l = 3;
        step(1'b1, 1'b0, 16'h3333);
        drain(300);

        // txen never rises: timeout, gap, then the next word still issues.
        fix_to = 1'b1;
        step(1'b1, 1'b0, 16'h4444);
        step(1'b1, 1'b0, 16'h5555);
        drain(200);

        // Randomized traffic with random MAC behaviour.
        fix_mac = 1'b0;
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), 16'($urandom));
        drain(500);

        // Reset during WAIT_DONE with three words queued.
        fix_mac = 1'b1; fix_a = 2; fix_l = 30; fix_to = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'h6000 + 16'(i));
        repeat (6) step(1'b0, 1'b0, 16'h0);
        do_reset();
        repeat (40) step(1'b0, 1'b0, 16'h0);
        fix_l = 5;
        step(1'b1, 1'b0, 16'h7777);
        drain(200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
